// File: rtl/qsub_serial.sv
// Bit-serial sign-magnitude subtractor c = a - b (Q/N format): one magnitude bit per clock behind valid/ready.
// Optional QSUB_SATURATE_EN: clamp magnitude to all ones on overflow instead of wrapping.
module qsub_serial #(
    parameter int Q = 14,
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam int M  = N - 1;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    if (N < 3 || Q < 0 || Q > N - 1) begin : g_param_check
        $error("qsub_serial: need N >= 3 and 0 <= Q <= N-1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    x_q, x_d;
    logic [M-1:0]    y_q, y_d;
    logic [M-1:0]    r_q, r_d;
    logic            carry_q, carry_d;
    logic            add_q, add_d;
    logic            sign_q, sign_d;
    logic [N-1:0]    c_q, c_d;
    logic            ovf_q, ovf_d;

    logic            sb_eff;
    logic            swap;
    logic            yb;
    logic            sum;
    logic            cout;
    logic [M-1:0]    r_shift;
    logic            last;
    logic            ovf_fin;
    logic [M-1:0]    mag_fin;
    logic            sign_fin;

    assign sb_eff  = ~b[N-1];
    assign swap    = b[M-1:0] > a[M-1:0];
    // SUB is x + ~y + 1: invert the subtrahend bit and seed the carry with 1.
    assign yb      = add_q ? y_q[0] : ~y_q[0];
    assign sum     = x_q[0] ^ yb ^ carry_q;
    assign cout    = (x_q[0] & yb) | (x_q[0] & carry_q) | (yb & carry_q);
    assign r_shift = {sum, r_q[M-1:1]};
    assign last    = (cnt_q == CW'(M - 1));
    assign ovf_fin = add_q & cout;

    always_comb begin
        mag_fin = r_shift;
`ifdef QSUB_SATURATE_EN
        if (ovf_fin) mag_fin = '1;
`endif
        sign_fin = sign_q & (|mag_fin);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        carry_d = carry_q;
        add_d   = add_q;
        sign_d  = sign_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    r_d     = '0;
                    add_d   = (a[N-1] == sb_eff);
                    carry_d = (a[N-1] != sb_eff);
                    if (a[N-1] != sb_eff && swap) begin
                        x_d    = b[M-1:0];
                        y_d    = a[M-1:0];
                        sign_d = sb_eff;
                    end else begin
                        x_d    = a[M-1:0];
                        y_d    = b[M-1:0];
                        sign_d = a[N-1];
                    end
                end
            end
            S_RUN: begin
                x_d     = x_q >> 1;
                y_d     = y_q >> 1;
                r_d     = r_shift;
                carry_d = cout;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = S_DONE;
                    c_d     = {sign_fin, mag_fin};
                    ovf_d   = ovf_fin;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            add_q   <= 1'b0;
            sign_q  <= 1'b0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            add_q   <= add_d;
            sign_q  <= sign_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign c         = c_q;
    assign ovf       = ovf_q;

endmodule
